// File: rtl/pc_sequencer_pkg.sv
// Shared CPU definitions for the PC sequencer: widths, sequencer states, PC increment.
package pc_sequencer_pkg;

  localparam int unsigned XLEN  = 32;
  localparam int unsigned JT_W  = 26;
  localparam int unsigned IMM_W = 16;

  localparam logic [XLEN-1:0] PC_INC = 32'd4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_EXEC  = 2'd2
  } state_e;

endpackage

// File: rtl/pc_sequencer_next_pc_calc.sv
// Combinational next-PC selection: jump over taken branch over sequential.
module next_pc_calc
  import pc_sequencer_pkg::*;
(
  input  logic [XLEN-1:0]  pc,
  input  logic             jump,
  input  logic [JT_W-1:0]  jump_target,
  input  logic             branch_take,
  input  logic [IMM_W-1:0] branch_imm,
  output logic [XLEN-1:0]  pc_plus4,
  output logic [XLEN-1:0]  next_pc
);

  logic [XLEN-1:0] br_off;

  assign pc_plus4 = pc + PC_INC;
  // Word offset sign-extended and scaled to bytes; overflow wraps silently.
  assign br_off   = {{(XLEN-IMM_W-2){branch_imm[IMM_W-1]}}, branch_imm, 2'b00};

  always_comb begin
    next_pc = pc_plus4;
    if (jump) begin
      next_pc = {pc_plus4[XLEN-1:XLEN-4], jump_target, 2'b00};
    end else if (branch_take) begin
      next_pc = pc_plus4 + br_off;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Fetch/execute program-counter sequencer with an instruction-memory request handshake.
module pc_sequencer
  import pc_sequencer_pkg::*;
#(
  parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             halt,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic             imem_ack,
  output logic             fetch_valid,
  input  logic             stall,
  input  logic             jump,
  input  logic [JT_W-1:0]  jump_target,
  input  logic             branch_take,
  input  logic [IMM_W-1:0] branch_imm,
  output logic [XLEN-1:0]  pc,
  output logic [XLEN-1:0]  pc_plus4,
  output logic             busy
);

  state_e          state_q, state_d;
  logic [XLEN-1:0] pc_q, pc_d;
  logic            req_q, req_d;
  logic            fv_q, fv_d;
  logic            busy_q, busy_d;
  logic [XLEN-1:0] next_pc;

  next_pc_calc u_next_pc_calc (
    .pc          (pc_q),
    .jump        (jump),
    .jump_target (jump_target),
    .branch_take (branch_take),
    .branch_imm  (branch_imm),
    .pc_plus4    (pc_plus4),
    .next_pc     (next_pc)
  );

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    req_d   = req_q;
    fv_d    = 1'b0;
    busy_d  = busy_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_FETCH;
          req_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      ST_FETCH: begin
        req_d = 1'b1;
        if (imem_ack) begin
          state_d = ST_EXEC;
          req_d   = 1'b0;
          fv_d    = 1'b1;
        end
      end
      ST_EXEC: begin
        // A stalled EXEC cycle freezes everything, including halt/jump/branch.
        if (!stall) begin
          pc_d = next_pc;
          if (halt) begin
            state_d = ST_IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = ST_FETCH;
            req_d   = 1'b1;
          end
        end
      end
      default: begin
        state_d = ST_IDLE;
        req_d   = 1'b0;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      pc_q    <= RESET_PC;
      req_q   <= 1'b0;
      fv_q    <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pc_q    <= pc_d;
      req_q   <= req_d;
      fv_q    <= fv_d;
      busy_q  <= busy_d;
    end
  end

  assign imem_req    = req_q;
  assign imem_addr   = pc_q;
  assign fetch_valid = fv_q;
  assign pc          = pc_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed scoreboard bench for pc_sequencer: expected fetch addresses are queued as EXEC decisions are driven.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        halt = 1'b0;
  logic        imem_ack = 1'b0;
  logic        stall = 1'b0;
  logic        jump = 1'b0;
  logic        branch_take = 1'b0;
  logic [25:0] jump_target = '0;
  logic [15:0] branch_imm = '0;
  logic        imem_req, fetch_valid, busy;
  logic [31:0] imem_addr, pc, pc_plus4;

  int          checks = 0;
  int          failures = 0;
  int          fv_cnt = 0;
  int          fv_snap;
  logic [31:0] model_pc;
  logic [31:0] addr_q[$];

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .halt        (halt),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .fetch_valid (fetch_valid),
    .stall       (stall),
    .jump        (jump),
    .jump_target (jump_target),
    .branch_take (branch_take),
    .branch_imm  (branch_imm),
    .pc          (pc),
    .pc_plus4    (pc_plus4),
    .busy        (busy)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (fetch_valid === 1'b1) fv_cnt <= fv_cnt + 1;

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] p, input logic j, input logic [25:0] jt,
                                           input logic b, input logic [15:0] bi);
    logic [31:0] p4;
    logic [31:0] sx;
    p4 = p + 32'd4;
    sx = {{16{bi[15]}}, bi};
    if (j) return {p4[31:28], jt, 2'b00};
    if (b) return p4 + (sx << 2);
    return p4;
  endfunction

  task automatic start_run();
    start = 1'b1;
    addr_q.push_back(model_pc);
    @(negedge clk);
    start = 1'b0;
    chk("start_busy", 32'(busy), 32'd1);
  endtask

  // One fetch/execute round; entered and left at a falling edge.
  task automatic instr(input string tag, input int ack_wait, input int stall_n, input logic j,
                       input logic [25:0] jt, input logic b, input logic [15:0] bi, input logic h);
    int n;
    logic [31:0] exp_addr;
    n = 0;
    while (imem_req !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_req"}, 32'(imem_req), 32'd1);
    if (addr_q.size() != 0) exp_addr = addr_q.pop_front();
    else exp_addr = 32'hDEAD_BEEF;
    chk({tag, "_addr"}, imem_addr, exp_addr);
    chk({tag, "_pc4"}, pc_plus4, exp_addr + 32'd4);
    for (int k = 0; k < ack_wait; k++) begin
      imem_ack = 1'b0;
      @(negedge clk);
      chk({tag, "_wait_req"}, 32'(imem_req), 32'd1);
      chk({tag, "_wait_addr"}, imem_addr, exp_addr);
      chk({tag, "_wait_fv"}, 32'(fetch_valid), 32'd0);
    end
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    chk({tag, "_fv"}, 32'(fetch_valid), 32'd1);
    chk({tag, "_exec_req"}, 32'(imem_req), 32'd0);
    for (int k = 0; k < stall_n; k++) begin
      stall = 1'b1;
      jump = 1'b1;
      branch_take = 1'b1;
      halt = 1'b1;
      jump_target = 26'h0000155;
      @(negedge clk);
      chk({tag, "_stall_fv"}, 32'(fetch_valid), 32'd0);
      chk({tag, "_stall_pc"}, pc, model_pc);
      chk({tag, "_stall_busy"}, 32'(busy), 32'd1);
    end
    stall = 1'b0;
    jump = j;
    jump_target = jt;
    branch_take = b;
    branch_imm = bi;
    halt = h;
    model_pc = ref_next(model_pc, j, jt, b, bi);
    if (!h) addr_q.push_back(model_pc);
    @(negedge clk);
    jump = 1'b0;
    branch_take = 1'b0;
    halt = 1'b0;
    chk({tag, "_pc"}, pc, model_pc);
    chk({tag, "_req_next"}, 32'(imem_req), 32'(!h));
    chk({tag, "_busy"}, 32'(busy), 32'(!h));
  endtask

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_pc", pc, 32'h0000_0000);
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_fv", 32'(fetch_valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);

    rst = 1'b0;
    imem_ack = 1'b1;
    repeat (3) @(negedge clk);
    imem_ack = 1'b0;
    chk("idle_req", 32'(imem_req), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
    chk("idle_fv_cnt", 32'(fv_cnt), 32'd0);

    model_pc = 32'h0;
    start_run();
    instr("seq0", 0, 0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0);
    instr("seq1", 0, 0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0);
    instr("seq2", 0, 0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0);
    instr("seq3", 0, 0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0);
    chk("seq_fv_cnt", 32'(fv_cnt), 32'd4);

    instr("jmp100", 0, 0, 1'b1, 26'h0000040, 1'b0, 16'h0, 1'b0);
    chk("jmp100_lit", pc, 32'h0000_0100);
    instr("brneg", 0, 0, 1'b0, 26'h0, 1'b1, 16'hFFFC, 1'b0);
    chk("brneg_lit", pc, 32'h0000_00F4);
    instr("jmpback", 0, 0, 1'b1, 26'h0000040, 1'b0, 16'h0, 1'b0);
    instr("brpos", 0, 0, 1'b0, 26'h0, 1'b1, 16'h0003, 1'b0);
    chk("brpos_lit", pc, 32'h0000_0110);

    fv_snap = fv_cnt;
    instr("ackwait", 5, 3, 1'b1, 26'h3FF_FFFF, 1'b0, 16'h0, 1'b0);
    chk("ackwait_lit", pc, 32'h0FFF_FFFC);
    chk("ackwait_one_fv", 32'(fv_cnt - fv_snap), 32'd1);
    instr("cross", 0, 0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b0);
    chk("cross_lit", pc, 32'h1000_0000);
    instr("br10", 0, 0, 1'b0, 26'h0, 1'b1, 16'h0003, 1'b0);
    chk("br10_lit", pc, 32'h1000_0010);
    instr("jwin", 0, 0, 1'b1, 26'h0000040, 1'b1, 16'h7FFF, 1'b0);
    chk("jwin_lit", pc, 32'h1000_0100);

    // Now in FETCH at a falling edge; reset lands between clock edges.
    chk("midrst_pre_req", 32'(imem_req), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("midrst_req", 32'(imem_req), 32'd0);
    chk("midrst_pc", pc, 32'h0000_0000);
    chk("midrst_busy", 32'(busy), 32'd0);
    addr_q.delete();
    model_pc = 32'h0;
    @(negedge clk);
    rst = 1'b0;
    fv_snap = fv_cnt;
    imem_ack = 1'b1;
    @(negedge clk);
    imem_ack = 1'b0;
    @(negedge clk);
    chk("midrst_ack_fv", 32'(fv_cnt - fv_snap), 32'd0);
    chk("midrst_ack_req", 32'(imem_req), 32'd0);

    start_run();
    instr("wrapbr", 0, 0, 1'b0, 26'h0, 1'b1, 16'hFFFE, 1'b0);
    chk("wrapbr_lit", pc, 32'hFFFF_FFFC);
    chk("wrapbr_pc4", pc_plus4, 32'h0000_0000);
    instr("wraphalt", 0, 0, 1'b0, 26'h0, 1'b0, 16'h0, 1'b1);
    chk("wraphalt_lit", pc, 32'h0000_0000);
    @(negedge clk);
    chk("halt_idle_req", 32'(imem_req), 32'd0);
    chk("halt_idle_busy", 32'(busy), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
